// File: rtl/eth_idma_pkg.sv
// Shared descriptor/response types and default sizing for the iDMA request queue.
package eth_idma_pkg;

   typedef struct packed {
      logic [31:0] src_addr;
      logic [31:0] dst_addr;
      logic [15:0] length;
   } idma_req_t;

   typedef struct packed {
      logic error;
   } idma_rsp_t;

   localparam int unsigned EthIdmaQueueDepth     = 4;
   localparam int unsigned EthIdmaMaxOutstanding = 3;

endpackage

// File: rtl/fifo_v3.sv
// Registered (non fall-through) FIFO; a push while full is dropped even if a pop
// happens in the same cycle.
module fifo_v3 #(
   parameter int unsigned DEPTH = 4,
   parameter type dtype = logic,
   localparam int unsigned AddrDepth = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [AddrDepth-1:0] usage_o,
   input  dtype                 data_i,
   input  logic                 push_i,
   output dtype                 data_o,
   input  logic                 pop_i
);

   logic [AddrDepth-1:0] rd_ptr_q, wr_ptr_q;
   logic [AddrDepth:0]   cnt_q;
   dtype                 mem_q [DEPTH];
   logic                 do_push, do_pop;

   assign full_o  = (cnt_q == (AddrDepth + 1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign usage_o = cnt_q[AddrDepth-1:0];
   assign data_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   function automatic logic [AddrDepth-1:0] bump(input logic [AddrDepth-1:0] p);
      return (p == AddrDepth'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= bump(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= bump(rd_ptr_q);
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/eth_idma_req_queue.sv
// Descriptor queue in front of an iDMA backend with outstanding-request cap,
// completion counter and sticky error. ETH_IDMA_REQ_QUEUE_IRQ_EN adds a completion irq pulse.
module eth_idma_req_queue
   import eth_idma_pkg::*;
#(
   parameter int unsigned Depth          = EthIdmaQueueDepth,
   parameter int unsigned MaxOutstanding = EthIdmaMaxOutstanding,
   parameter type idma_req_t = eth_idma_pkg::idma_req_t,
   parameter type idma_rsp_t = eth_idma_pkg::idma_rsp_t,
   localparam int unsigned FillW = $clog2(Depth + 1),
   localparam int unsigned OutW  = $clog2(MaxOutstanding + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  idma_req_t        push_req_i,
   input  logic             push_valid_i,
   output logic             push_ready_o,
   output idma_req_t        idma_req_o,
   output logic             idma_req_valid_o,
   input  logic             idma_req_ready_i,
   input  idma_rsp_t        idma_rsp_i,
   input  logic             idma_rsp_valid_i,
   output logic             idma_rsp_ready_o,
   input  logic             clr_i,
   output logic [FillW-1:0] fill_o,
   output logic [OutW-1:0]  outstanding_o,
   output logic [31:0]      done_cnt_o,
   output logic             err_o,
   output logic             irq_o
);

   // Handshakes: a transfer happens on a cycle where valid && ready at the rising edge;
   // valid never depends on ready, and idma_req_o holds while valid && !ready.
   logic                       fifo_full, fifo_empty;
   logic [$clog2(Depth)-1:0]   fifo_usage;
   logic                       push_hs, issue_hs, rsp_hs;
   logic [OutW-1:0]            outstanding_q;
   logic [31:0]                done_cnt_q;
   logic                       err_q;

   fifo_v3 #(
      .DEPTH (Depth),
      .dtype (idma_req_t)
   ) i_desc_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (1'b0),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .usage_o (fifo_usage),
      .data_i  (push_req_i),
      .push_i  (push_hs),
      .data_o  (idma_req_o),
      .pop_i   (issue_hs)
   );

   // Full is exactly Depth, so the full flag is the MSB of the count above the usage bits.
   assign fill_o           = FillW'({fifo_full, fifo_usage});
   assign push_ready_o     = !fifo_full;
   assign idma_req_valid_o = !fifo_empty && (outstanding_q < OutW'(MaxOutstanding));
   assign idma_rsp_ready_o = (outstanding_q != '0);
   assign push_hs          = push_valid_i && push_ready_o;
   assign issue_hs         = idma_req_valid_o && idma_req_ready_i;
   assign rsp_hs           = idma_rsp_valid_i && idma_rsp_ready_o;
   assign outstanding_o    = outstanding_q;
   assign done_cnt_o       = done_cnt_q;
   assign err_o            = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
      end else if (issue_hs && !rsp_hs) begin
         outstanding_q <= outstanding_q + 1'b1;
      end else if (rsp_hs && !issue_hs) begin
         outstanding_q <= outstanding_q - 1'b1;
      end
   end

   // Clear takes priority over a completion landing in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_cnt_q <= '0;
         err_q      <= 1'b0;
      end else if (clr_i) begin
         done_cnt_q <= '0;
         err_q      <= 1'b0;
      end else if (rsp_hs) begin
         done_cnt_q <= done_cnt_q + 32'd1;
         if (idma_rsp_i.error) err_q <= 1'b1;
      end
   end

`ifdef ETH_IDMA_REQ_QUEUE_IRQ_EN
   logic irq_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) irq_q <= 1'b0;
      else         irq_q <= rsp_hs;
   end
   assign irq_o = irq_q;
`else
   assign irq_o = 1'b0;
`endif

   no_rsp_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(idma_rsp_valid_i && (outstanding_q == '0)))
      else $error("response presented with no request outstanding");

endmodule
